// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcodes, funct codes,
// ALU operation set and architectural register indices.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] ZERO = 5'd0;
  localparam logic [4:0] RA   = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_NOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_LUI  = 4'd9
  } alu_op_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU with shifter and zero flag; the zero flag
// drives beq/bne resolution in the core.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select; shifts act on b (rt) by the instruction shamt field.
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_np_core.sv
// Single-cycle MIPS core with internal instruction/data memories and register
// file; one instruction retires on every clock edge while reset_in is high.
module mips_np_core
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        instr_clock_in,
  input  logic        instrWrite_in,
  input  logic [31:0] instr_address_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] read_data_address_in,
  output logic [31:0] read_instr_out,
  output logic [31:0] read_data_out
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem_r [IMEM_WORDS];
  logic [31:0] dmem_r [DMEM_WORDS];
  logic [31:0] regs_r [32];
  logic [31:0] pc_r;

  logic [31:0] instr_s;
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [15:0] imm_s;
  logic [25:0] target_s;

  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic [31:0] imm_ext_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_result_s;
  logic        alu_zero_s;
  logic [31:0] dmem_rd_s;
  logic [31:0] wb_data_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;
  logic [31:0] next_pc_s;

  alu_op_e     alu_op_s;
  logic        use_imm_s;
  logic        zext_s;
  logic        reg_write_s;
  logic [4:0]  dest_s;
  logic        mem_read_s;
  logic        mem_write_s;
  logic        branch_eq_s;
  logic        branch_ne_s;
  logic        jump_s;
  logic        link_s;
  logic        jump_reg_s;
  logic        unused_bits_s;

  assign instr_s  = imem_r[pc_r[IAW+1:2]];
  assign opcode_s = instr_s[31:26];
  assign rs_s     = instr_s[25:21];
  assign rt_s     = instr_s[20:16];
  assign rd_s     = instr_s[15:11];
  assign shamt_s  = instr_s[10:6];
  assign funct_s  = instr_s[5:0];
  assign imm_s    = instr_s[15:0];
  assign target_s = instr_s[25:0];

  // $0 is forced to zero on read so it never depends on stored contents.
  assign rs_val_s = (rs_s == ZERO) ? 32'd0 : regs_r[rs_s];
  assign rt_val_s = (rt_s == ZERO) ? 32'd0 : regs_r[rt_s];

  // Main control decode; anything unrecognised leaves all strobes low (nop).
  always_comb begin
    alu_op_s    = ALU_ADD;
    use_imm_s   = 1'b0;
    zext_s      = 1'b0;
    reg_write_s = 1'b0;
    dest_s      = rd_s;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    branch_eq_s = 1'b0;
    branch_ne_s = 1'b0;
    jump_s      = 1'b0;
    link_s      = 1'b0;
    jump_reg_s  = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_ADDU: begin alu_op_s = ALU_ADD;  reg_write_s = 1'b1; end
          FN_SUB, FN_SUBU: begin alu_op_s = ALU_SUB;  reg_write_s = 1'b1; end
          FN_AND:          begin alu_op_s = ALU_AND;  reg_write_s = 1'b1; end
          FN_OR:           begin alu_op_s = ALU_OR;   reg_write_s = 1'b1; end
          FN_NOR:          begin alu_op_s = ALU_NOR;  reg_write_s = 1'b1; end
          FN_SLT:          begin alu_op_s = ALU_SLT;  reg_write_s = 1'b1; end
          FN_SLTU:         begin alu_op_s = ALU_SLTU; reg_write_s = 1'b1; end
          FN_SLL:          begin alu_op_s = ALU_SLL;  reg_write_s = 1'b1; end
          FN_SRL:          begin alu_op_s = ALU_SRL;  reg_write_s = 1'b1; end
          FN_JR:           jump_reg_s = 1'b1;
          default:         reg_write_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        use_imm_s = 1'b1; reg_write_s = 1'b1; dest_s = rt_s;
      end
      OP_ANDI: begin
        alu_op_s = ALU_AND; use_imm_s = 1'b1; zext_s = 1'b1;
        reg_write_s = 1'b1; dest_s = rt_s;
      end
      OP_ORI: begin
        alu_op_s = ALU_OR; use_imm_s = 1'b1; zext_s = 1'b1;
        reg_write_s = 1'b1; dest_s = rt_s;
      end
      OP_SLTI: begin
        alu_op_s = ALU_SLT; use_imm_s = 1'b1; reg_write_s = 1'b1; dest_s = rt_s;
      end
      OP_LUI: begin
        alu_op_s = ALU_LUI; use_imm_s = 1'b1; reg_write_s = 1'b1; dest_s = rt_s;
      end
      OP_LW: begin
        use_imm_s = 1'b1; mem_read_s = 1'b1; reg_write_s = 1'b1; dest_s = rt_s;
      end
      OP_SW: begin
        use_imm_s = 1'b1; mem_write_s = 1'b1;
      end
      OP_BEQ: begin alu_op_s = ALU_SUB; branch_eq_s = 1'b1; end
      OP_BNE: begin alu_op_s = ALU_SUB; branch_ne_s = 1'b1; end
      OP_J:   jump_s = 1'b1;
      OP_JAL: begin
        jump_s = 1'b1; link_s = 1'b1; reg_write_s = 1'b1; dest_s = RA;
      end
      default: reg_write_s = 1'b0;
    endcase
  end

  assign imm_ext_s = zext_s ? {16'h0000, imm_s} : sign_ext16(imm_s);
  assign alu_b_s   = use_imm_s ? imm_ext_s : rt_val_s;

  mips_alu u_alu (
    .op     (alu_op_s),
    .a      (rs_val_s),
    .b      (alu_b_s),
    .shamt  (shamt_s),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  assign dmem_rd_s       = dmem_r[alu_result_s[DAW+1:2]];
  assign pc_plus4_s      = pc_r + 32'd4;
  assign branch_target_s = pc_plus4_s + {imm_ext_s[29:0], 2'b00};
  assign jump_target_s   = {pc_plus4_s[31:28], target_s, 2'b00};

  // Writeback source and next-PC selection.
  always_comb begin
    if (link_s) begin
      wb_data_s = pc_plus4_s;
    end else if (mem_read_s) begin
      wb_data_s = dmem_rd_s;
    end else begin
      wb_data_s = alu_result_s;
    end
    if (jump_reg_s) begin
      next_pc_s = rs_val_s;
    end else if (jump_s) begin
      next_pc_s = jump_target_s;
    end else if ((branch_eq_s && alu_zero_s) || (branch_ne_s && !alu_zero_s)) begin
      next_pc_s = branch_target_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Architectural state: PC and register file, both cleared by reset.
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      pc_r <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else begin
      pc_r <= next_pc_s;
      if (reg_write_s && (dest_s != ZERO)) begin
        regs_r[dest_s] <= wb_data_s;
      end
    end
  end

  // Data memory store port; contents survive reset.
  always_ff @(posedge clock_in) begin
    if (reset_in && mem_write_s) begin
      dmem_r[alu_result_s[DAW+1:2]] <= rt_val_s;
    end
  end

  // Instruction memory load port, accepted in reset and while running.
  always_ff @(posedge instr_clock_in) begin
    if (instrWrite_in) begin
      imem_r[instr_address_in[IAW+1:2]] <= instr_in;
    end
  end

  assign read_instr_out = imem_r[instr_address_in[IAW+1:2]];
  assign read_data_out  = dmem_r[read_data_address_in[DAW+1:2]];

  assign unused_bits_s = ^{instr_address_in[31:IAW+2], instr_address_in[1:0],
                           read_data_address_in[31:DAW+2], read_data_address_in[1:0]};

endmodule

// File: tb/tb_mips_np_core.sv
// Directed bench for mips_np_core: loads small hand-assembled programs and
// checks data memory against hand-computed tables.
module tb_mips_np_core;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        instrWrite_in;
  logic [31:0] instr_address_in;
  logic [31:0] instr_in;
  logic [31:0] read_data_address_in;
  logic [31:0] read_instr_out;
  logic [31:0] read_data_out;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] HALT = 32'h1000FFFF;

  typedef struct {
    int          word;
    logic [31:0] want;
  } mem_vec_t;

  mem_vec_t    fib_tab [10];
  mem_vec_t    misc_tab [14];
  logic [31:0] prog_r [48];
  logic [31:0] rd_v;

  always #5 clock_in = ~clock_in;

  mips_np_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clock_in             (clock_in),
    .reset_in             (reset_in),
    .instr_clock_in       (clock_in),
    .instrWrite_in        (instrWrite_in),
    .instr_address_in     (instr_address_in),
    .instr_in             (instr_in),
    .read_data_address_in (read_data_address_in),
    .read_instr_out       (read_instr_out),
    .read_data_out        (read_data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic read_mem(input int word, output logic [31:0] v);
    read_data_address_in = 32'(word) << 2;
    #1;
    v = read_data_out;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 48; i++) prog_r[i] = HALT;
  endtask

  // Holds reset low while writing the whole program image, then leaves reset low.
  task automatic load_prog();
    reset_in = 1'b0;
    for (int i = 0; i < 48; i++) begin
      instr_address_in = 32'(i) << 2;
      instr_in         = prog_r[i];
      instrWrite_in    = 1'b1;
      tick(1);
    end
    instrWrite_in = 1'b0;
  endtask

  initial begin
    reset_in = 1'b0;
    instrWrite_in = 1'b0;
    instr_address_in = 32'd0;
    instr_in = 32'd0;
    read_data_address_in = 32'd0;
    tick(2);

    fib_tab[0] = '{0, 32'd0};  fib_tab[1] = '{1, 32'd1};  fib_tab[2] = '{2, 32'd1};
    fib_tab[3] = '{3, 32'd2};  fib_tab[4] = '{4, 32'd3};  fib_tab[5] = '{5, 32'd5};
    fib_tab[6] = '{6, 32'd8};  fib_tab[7] = '{7, 32'd13}; fib_tab[8] = '{8, 32'd21};
    fib_tab[9] = '{9, 32'd34};

    misc_tab[0]  = '{0,  32'h12345678};  // lui/ori
    misc_tab[1]  = '{1,  32'h00000000};  // write to $0 discarded
    misc_tab[2]  = '{2,  32'd24};        // jal link = jal address + 4
    misc_tab[3]  = '{3,  32'hFFFFFFFD};  // resumed after jr
    misc_tab[4]  = '{4,  32'h1234567B};  // sub
    misc_tab[5]  = '{5,  32'd1};         // slt signed
    misc_tab[6]  = '{6,  32'd0};         // sltu unsigned
    misc_tab[7]  = '{7,  32'hEDCBA987};  // nor
    misc_tab[8]  = '{8,  32'h23456780};  // sll 4
    misc_tab[9]  = '{9,  32'h00FFFFFF};  // srl 8
    misc_tab[10] = '{10, 32'h0000FF00};  // andi zero-extends
    misc_tab[11] = '{11, 32'h12345678};  // lw then and
    misc_tab[12] = '{12, 32'd1};         // slti
    misc_tab[13] = '{13, 32'd1};         // beq taken skipped the addi

    // Load/readback and basic execution.
    clear_prog();
    prog_r[0] = 32'h20080005;  // addi $t0,$0,5
    prog_r[1] = 32'hAC080000;  // sw $t0,0($0)
    load_prog();
    instr_address_in = 32'd0; #1; check("readback0", read_instr_out, 32'h20080005);
    instr_address_in = 32'd4; #1; check("readback4", read_instr_out, 32'hAC080000);
    instr_address_in = 32'd8; #1; check("readback8", read_instr_out, HALT);
    reset_in = 1'b1;
    tick(2);
    read_mem(0, rd_v); check("basic_sw", rd_v, 32'd5);

    // Count loop 1..10 with a store each iteration.
    clear_prog();
    prog_r[0] = 32'h20080000;  // addi $t0,$0,0
    prog_r[1] = 32'h2009000A;  // addi $t1,$0,10
    prog_r[2] = 32'h21080001;  // addi $t0,$t0,1
    prog_r[3] = 32'hAC080000;  // sw $t0,0($0)
    prog_r[4] = 32'h1509FFFD;  // bne $t0,$t1,-3
    prog_r[5] = 32'hAC090004;  // sw $t1,4($0)
    load_prog();
    reset_in = 1'b1;
    tick(1);
    for (int k = 1; k <= 10; k++) begin
      tick(3);
      read_mem(0, rd_v); check($sformatf("count_%0d", k), rd_v, 32'(k));
    end
    tick(2);
    read_mem(1, rd_v); check("count_done", rd_v, 32'd10);
    read_mem(0, rd_v); check("count_final", rd_v, 32'd10);

    // Reset mid-run: PC and registers clear, data memory is retained.
    reset_in = 1'b0; tick(1); reset_in = 1'b1;
    tick(16);
    read_mem(0, rd_v); check("rerun_at5", rd_v, 32'd5);
    reset_in = 1'b0; tick(1);
    read_mem(0, rd_v); check("reset_keeps_mem0", rd_v, 32'd5);
    read_mem(1, rd_v); check("reset_keeps_mem1", rd_v, 32'd10);
    reset_in = 1'b1;
    tick(3);
    read_mem(0, rd_v); check("restart_before_sw", rd_v, 32'd5);
    tick(1);
    read_mem(0, rd_v); check("restart_count1", rd_v, 32'd1);

    // Fibonacci F0..F9 into words 0..9.
    clear_prog();
    prog_r[0] = 32'h20090001;  // addi $t1,$0,1
    prog_r[1] = 32'h200B0028;  // addi $t3,$0,40
    prog_r[2] = 32'hAD480000;  // sw $t0,0($t2)
    prog_r[3] = 32'h01096020;  // add $t4,$t0,$t1
    prog_r[4] = 32'h01204020;  // add $t0,$t1,$0
    prog_r[5] = 32'h01804820;  // add $t1,$t4,$0
    prog_r[6] = 32'h214A0004;  // addi $t2,$t2,4
    prog_r[7] = 32'h154BFFFA;  // bne $t2,$t3,-6
    load_prog();
    reset_in = 1'b1;
    tick(70);
    for (int i = 0; i < 10; i++) begin
      read_mem(fib_tab[i].word, rd_v);
      check($sformatf("fib_%0d", i), rd_v, fib_tab[i].want);
    end

    // lui/ori, $0, jal/jr and assorted ALU operations.
    clear_prog();
    prog_r[0]  = 32'h3C091234;  // lui $t1,0x1234
    prog_r[1]  = 32'h35295678;  // ori $t1,$t1,0x5678
    prog_r[2]  = 32'hAC090000;  // sw $t1,0($0)
    prog_r[3]  = 32'h20000007;  // addi $0,$0,7
    prog_r[4]  = 32'hAC000004;  // sw $0,4($0)
    prog_r[5]  = 32'h0C00000A;  // jal 40
    prog_r[6]  = 32'h2008FFFD;  // addi $t0,$0,-3
    prog_r[7]  = 32'hAC08000C;  // sw $t0,12($0)
    prog_r[8]  = 32'h08000010;  // j 64
    prog_r[10] = 32'hAC1F0008;  // sw $31,8($0)
    prog_r[11] = 32'h03E00008;  // jr $31
    prog_r[16] = 32'h01285022;  // sub $t2,$t1,$t0
    prog_r[17] = 32'hAC0A0010;  // sw $t2,16($0)
    prog_r[18] = 32'h0109502A;  // slt $t2,$t0,$t1
    prog_r[19] = 32'h0109582B;  // sltu $t3,$t0,$t1
    prog_r[20] = 32'hAC0A0014;  // sw $t2,20($0)
    prog_r[21] = 32'hAC0B0018;  // sw $t3,24($0)
    prog_r[22] = 32'h01205027;  // nor $t2,$t1,$0
    prog_r[23] = 32'h00095900;  // sll $t3,$t1,4
    prog_r[24] = 32'hAC0A001C;  // sw $t2,28($0)
    prog_r[25] = 32'hAC0B0020;  // sw $t3,32($0)
    prog_r[26] = 32'h00085202;  // srl $t2,$t0,8
    prog_r[27] = 32'h310BFF00;  // andi $t3,$t0,0xFF00
    prog_r[28] = 32'hAC0A0024;  // sw $t2,36($0)
    prog_r[29] = 32'hAC0B0028;  // sw $t3,40($0)
    prog_r[30] = 32'h8C0C0010;  // lw $t4,16($0)
    prog_r[31] = 32'h01895024;  // and $t2,$t4,$t1
    prog_r[32] = 32'h290BFFFE;  // slti $t3,$t0,-2
    prog_r[33] = 32'hAC0A002C;  // sw $t2,44($0)
    prog_r[34] = 32'hAC0B0030;  // sw $t3,48($0)
    prog_r[35] = 32'h11090001;  // beq $t0,$t1,+1 (not taken)
    prog_r[36] = 32'h11080001;  // beq $t0,$t0,+1 (taken)
    prog_r[37] = 32'h200B0063;  // addi $t3,$0,99 (skipped)
    prog_r[38] = 32'hAC0B0034;  // sw $t3,52($0)
    load_prog();
    reset_in = 1'b1;
    tick(45);
    for (int i = 0; i < 14; i++) begin
      read_mem(misc_tab[i].word, rd_v);
      check($sformatf("misc_word%0d", misc_tab[i].word), rd_v, misc_tab[i].want);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
